// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Counts shifts since the last load or reset and pulses done when the count
// first reaches WIDTH.
// Optional feature: define SHIFT_ROTATE_EN to add the rot port. With rot=1,
// shifts recirculate the outgoing bit instead of taking sin_r/sin_l.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       sin_r,
    input  logic                       sin_l,
    input  logic [WIDTH-1:0]           pin,
`ifdef SHIFT_ROTATE_EN
    input  logic                       rot,
`endif
    output logic [WIDTH-1:0]           q,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [1:0] ModeHold  = 2'b00;
    localparam logic [1:0] ModeRight = 2'b01;
    localparam logic [1:0] ModeLeft  = 2'b10;
    localparam logic [1:0] ModeLoad  = 2'b11;

    logic [WIDTH-1:0] q_d;
    logic [CntW-1:0]  cnt_d;
    logic             done_d;
    logic             fill_r;
    logic             fill_l;
    logic             shift;

    // Select the bit entering on each shift direction.
`ifdef SHIFT_ROTATE_EN
    always_comb begin
        fill_r = rot ? q[0] : sin_r;
        fill_l = rot ? q[WIDTH-1] : sin_l;
    end
`else
    always_comb begin
        fill_r = sin_r;
        fill_l = sin_l;
    end
`endif

    // Next-state for data, shift count and completion pulse.
    always_comb begin
        q_d    = q;
        cnt_d  = cnt;
        done_d = 1'b0;
        shift  = en && ((mode == ModeRight) || (mode == ModeLeft));
        if (en) begin
            unique case (mode)
                ModeHold:  q_d = q;
                ModeRight: q_d = {fill_r, q[WIDTH-1:1]};
                ModeLeft:  q_d = {q[WIDTH-2:0], fill_l};
                ModeLoad: begin
                    q_d   = pin;
                    cnt_d = '0;
                end
                default:   q_d = q;
            endcase
        end
        if (shift && (cnt != CntMax)) begin
            cnt_d = cnt + 1'b1;
        end
        // Only the transition into saturation fires done.
        if (shift && (cnt == CntLast)) begin
            done_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            q    <= q_d;
            cnt  <= cnt_d;
            done <= done_d;
        end
    end

    // Serial outputs are taps of the register.
    always_comb begin
        sout_r = q[0];
        sout_l = q[WIDTH-1];
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8.
// Rotate scenario is built only when SHIFT_ROTATE_EN is defined.
module tb_univ_shift_reg;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] pin;
`ifdef SHIFT_ROTATE_EN
    logic       rot;
`endif
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic [3:0] cnt;
    logic       done;

    int total;
    int bad;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .pin    (pin),
`ifdef SHIFT_ROTATE_EN
        .rot    (rot),
`endif
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .cnt    (cnt),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        en = 1'b1; mode = 2'b11; pin = v;
        tick();
    endtask

    task automatic do_shift(input logic [1:0] m, input logic sr, input logic sl);
        en = 1'b1; mode = m; sin_r = sr; sin_l = sl;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        do_load(8'hA5);
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL rst_preload q=%h exp=a5", q); end
        // Reset edge between clocks must not affect outputs.
        reset = 1'b0; mode = 2'b11; pin = 8'hFF; en = 1'b1;
        #2;
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL rst_async q=%h exp=a5", q); end
        tick();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_q q=%h exp=00", q); end
        total++; if (cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt cnt=%0d exp=0", cnt); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done done=%b exp=0", done); end
        reset = 1'b1;
    endtask

    task automatic test_shift_right();
        do_load(8'h81);
        total++; if (sout_r !== 1'b1 || sout_l !== 1'b1) begin
            bad++; $display("FAIL load81_sout sout_r=%b sout_l=%b exp=1,1", sout_r, sout_l);
        end
        do_shift(2'b01, 1'b0, 1'b0);
        total++; if (q !== 8'h40) begin bad++; $display("FAIL shr1_q q=%h exp=40", q); end
        total++; if (sout_r !== 1'b0) begin bad++; $display("FAIL shr1_sout_r got=%b exp=0", sout_r); end
        total++; if (cnt !== 4'd1) begin bad++; $display("FAIL shr1_cnt cnt=%0d exp=1", cnt); end
        do_shift(2'b01, 1'b1, 1'b0);
        total++; if (q !== 8'hA0) begin bad++; $display("FAIL shr2_q q=%h exp=a0", q); end
        total++; if (sout_l !== 1'b1) begin bad++; $display("FAIL shr2_sout_l got=%b exp=1", sout_l); end
        total++; if (cnt !== 4'd2) begin bad++; $display("FAIL shr2_cnt cnt=%0d exp=2", cnt); end
    endtask

    task automatic test_shift_left_sat();
        logic [7:0] exp_q [1:8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        do_load(8'h00);
        for (int i = 1; i <= 8; i++) begin
            do_shift(2'b10, 1'b0, 1'b1);
            total++; if (q !== exp_q[i]) begin
                bad++; $display("FAIL shl_q step=%0d q=%h exp=%h", i, q, exp_q[i]);
            end
            total++; if (cnt !== 4'(i)) begin
                bad++; $display("FAIL shl_cnt step=%0d cnt=%0d exp=%0d", i, cnt, i);
            end
            total++; if (done !== (i == 8)) begin
                bad++; $display("FAIL shl_done step=%0d done=%b exp=%b", i, done, (i == 8));
            end
        end
        do_shift(2'b10, 1'b0, 1'b1);
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL shl9_q q=%h exp=ff", q); end
        total++; if (cnt !== 4'd8) begin bad++; $display("FAIL shl9_cnt cnt=%0d exp=8", cnt); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL shl9_done done=%b exp=0", done); end
    endtask

    task automatic test_enable_hold();
        do_load(8'h3C);
        en = 1'b0; mode = 2'b01; sin_r = 1'b1;
        repeat (3) tick();
        total++; if (q !== 8'h3C) begin bad++; $display("FAIL en0_q q=%h exp=3c", q); end
        total++; if (cnt !== 4'd0) begin bad++; $display("FAIL en0_cnt cnt=%0d exp=0", cnt); end
        en = 1'b1; mode = 2'b00;
        tick();
        total++; if (q !== 8'h3C) begin bad++; $display("FAIL hold_q q=%h exp=3c", q); end
        total++; if (cnt !== 4'd0) begin bad++; $display("FAIL hold_cnt cnt=%0d exp=0", cnt); end
    endtask

    task automatic test_reload_mixed();
        int pulses;
        do_load(8'h00);
        repeat (5) do_shift(2'b01, 1'b0, 1'b0);
        total++; if (cnt !== 4'd5) begin bad++; $display("FAIL pre_cnt cnt=%0d exp=5", cnt); end
        do_load(8'h12);
        total++; if (q !== 8'h12 || cnt !== 4'd0 || done !== 1'b0) begin
            bad++; $display("FAIL reload q=%h cnt=%0d done=%b exp=12,0,0", q, cnt, done);
        end
        // 4 right shifts then 4 left: 12->09->04->02->01->03->07->0f->1f
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i <= 4) do_shift(2'b01, 1'b0, 1'b0);
            else        do_shift(2'b10, 1'b0, 1'b1);
            if (done) pulses++;
        end
        total++; if (q !== 8'h1F) begin bad++; $display("FAIL mixed_q q=%h exp=1f", q); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mixed_done8 done=%b exp=1", done); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL mixed_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_reset_priority();
        do_load(8'hC3);
        do_shift(2'b01, 1'b1, 1'b0);
        reset = 1'b0; en = 1'b1; mode = 2'b01; sin_r = 1'b1;
        tick();
        total++; if (q !== 8'h00 || cnt !== 4'd0) begin
            bad++; $display("FAIL rst_prio q=%h cnt=%0d exp=00,0", q, cnt);
        end
        reset = 1'b1;
    endtask

`ifdef SHIFT_ROTATE_EN
    task automatic test_rotate();
        rot = 1'b0;
        do_load(8'h01);
        rot = 1'b1;
        do_shift(2'b01, 1'b0, 1'b0);
        total++; if (q !== 8'h80) begin bad++; $display("FAIL rotr_q q=%h exp=80", q); end
        do_shift(2'b10, 1'b0, 1'b0);
        total++; if (q !== 8'h01) begin bad++; $display("FAIL rotl_q q=%h exp=01", q); end
        total++; if (cnt !== 4'd2) begin bad++; $display("FAIL rot_cnt cnt=%0d exp=2", cnt); end
        rot = 1'b0;
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pin = 8'h00;
`ifdef SHIFT_ROTATE_EN
        rot = 1'b0;
`endif
        #1;
        test_reset();
        test_shift_right();
        test_shift_left_sat();
        test_enable_hold();
        test_reload_mixed();
        test_reset_priority();
`ifdef SHIFT_ROTATE_EN
        test_rotate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
